// File: rtl/spi_device_mem.sv
// SPI responder turning command/address/data frames into single-word memory requests.
// Optional status command (8'h05) is built when SPI_STATUS_CMD_EN is defined.
module spi_device_mem #(
  parameter int unsigned DUMMY_CYCLES = 34,
  parameter logic [7:0]  CMD_WRITE    = 8'h02,
  parameter logic [7:0]  CMD_READ     = 8'h0B
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  input  logic        spi_cs,
  output logic        spi_sdo,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic        cmd_err_o,
  output logic        rd_late_o
);

  localparam int unsigned CntW = (DUMMY_CYCLES > 32) ? $clog2(DUMMY_CYCLES) : 5;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE
  } state_e;

  // Input synchronisers; chip select resets to its idle (high) level.
  logic [1:0] sclk_sync_q, sdi_sync_q, cs_sync_q;
  logic       sclk_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= 2'b00;
      sdi_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
      sdi_sync_q  <= {sdi_sync_q[0], spi_sdi};
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  logic sdi_s, cs_s, rise_c, fall_c;
  assign sdi_s  = sdi_sync_q[1];
  assign cs_s   = cs_sync_q[1];
  assign rise_c = sclk_sync_q[1] & ~sclk_prev_q;
  assign fall_c = ~sclk_sync_q[1] & sclk_prev_q;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [30:0]     shift_q;
  logic [31:0]     tx_q;
  logic [31:0]     addr_q;
  logic            rd_cmd_q;
  logic            have_data_q;
  logic            sdo_q;
  logic            cmd_err_q;
  logic            rd_late_q;
  logic            rd_pend_q;

  logic [31:0] shift_nxt_c;
  logic        last_c;
  logic        cap_c;
  assign shift_nxt_c = {shift_q, sdi_s};
  assign last_c      = rise_c && (cnt_q == '0) && !cs_s;
  assign cap_c       = mem_rvalid_i && rd_pend_q;

`ifdef SPI_STATUS_CMD_EN
  localparam logic [7:0] CmdStatus = 8'h05;
  logic rd_late_sticky_q, cmd_err_sticky_q;
  logic status_rd_c;
  assign status_rd_c = (state_q == CMD) && last_c && (shift_nxt_c[7:0] == CmdStatus);

  // Sticky error flags, cleared when the status byte is read out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_late_sticky_q <= 1'b0;
      cmd_err_sticky_q <= 1'b0;
    end else if (status_rd_c) begin
      rd_late_sticky_q <= 1'b0;
      cmd_err_sticky_q <= 1'b0;
    end else begin
      if (rd_late_q) rd_late_sticky_q <= 1'b1;
      if (cmd_err_q) cmd_err_sticky_q <= 1'b1;
    end
  end
`endif

  // Protocol FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rd_cmd_q    <= 1'b0;
      have_data_q <= 1'b0;
      sdo_q       <= 1'b0;
      cmd_err_q   <= 1'b0;
      rd_late_q   <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      rd_late_q <= 1'b0;
      if (cs_s) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sdo_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= CMD;
            cnt_q   <= CntW'(7);
          end
          CMD: begin
            if (rise_c) begin
              shift_q <= shift_nxt_c[30:0];
              if (cnt_q == '0) begin
                if (shift_nxt_c[7:0] == CMD_WRITE || shift_nxt_c[7:0] == CMD_READ) begin
                  rd_cmd_q <= (shift_nxt_c[7:0] == CMD_READ);
                  state_q  <= ADDR;
                  cnt_q    <= CntW'(31);
                end
`ifdef SPI_STATUS_CMD_EN
                else if (shift_nxt_c[7:0] == CmdStatus) begin
                  state_q <= RDATA;
                  cnt_q   <= CntW'(7);
                  tx_q    <= {6'b0, rd_late_sticky_q, cmd_err_sticky_q, 24'b0};
                end
`endif
                else begin
                  cmd_err_q <= 1'b1;
                  state_q   <= IGNORE;
                end
              end else begin
                cnt_q <= cnt_q - CntW'(1);
              end
            end
          end
          ADDR: begin
            if (rise_c) begin
              shift_q <= shift_nxt_c[30:0];
              if (cnt_q == '0) begin
                if (rd_cmd_q) begin
                  state_q     <= DUMMY;
                  cnt_q       <= CntW'(DUMMY_CYCLES - 1);
                  have_data_q <= 1'b0;
                end else begin
                  addr_q  <= shift_nxt_c;
                  state_q <= WDATA;
                  cnt_q   <= CntW'(31);
                end
              end else begin
                cnt_q <= cnt_q - CntW'(1);
              end
            end
          end
          WDATA: begin
            if (rise_c) begin
              shift_q <= shift_nxt_c[30:0];
              if (cnt_q == '0) begin
                state_q <= CMD;
                cnt_q   <= CntW'(7);
              end else begin
                cnt_q <= cnt_q - CntW'(1);
              end
            end
          end
          DUMMY: begin
            sdo_q <= 1'b0;
            if (cap_c) begin
              tx_q        <= mem_rdata_i;
              have_data_q <= 1'b1;
            end
            if (rise_c) begin
              if (cnt_q == '0) begin
                state_q <= RDATA;
                cnt_q   <= CntW'(31);
                // Data missed the window: send zeros instead.
                if (!have_data_q && !cap_c) begin
                  rd_late_q <= 1'b1;
                  tx_q      <= '0;
                end
              end else begin
                cnt_q <= cnt_q - CntW'(1);
              end
            end
          end
          RDATA: begin
            if (fall_c) begin
              sdo_q <= tx_q[31];
              tx_q  <= {tx_q[30:0], 1'b0};
            end
            if (rise_c) begin
              if (cnt_q == '0) begin
                state_q <= CMD;
                cnt_q   <= CntW'(7);
                sdo_q   <= 1'b0;
              end else begin
                cnt_q <= cnt_q - CntW'(1);
              end
            end
          end
          IGNORE: begin
            sdo_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // A completed read address or write data phase produces a new request.
  logic        new_req_c;
  logic        new_we_c;
  logic [31:0] new_addr_c;
  always_comb begin
    new_req_c  = 1'b0;
    new_we_c   = 1'b0;
    new_addr_c = shift_nxt_c;
    if (last_c) begin
      if (state_q == ADDR && rd_cmd_q) begin
        new_req_c = 1'b1;
      end else if (state_q == WDATA) begin
        new_req_c  = 1'b1;
        new_we_c   = 1'b1;
        new_addr_c = addr_q;
      end
    end
  end

  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        pend_q, pend_we_q;
  logic [31:0] pend_addr_q, pend_wdata_q;

  // Request port with a one-entry holding slot; requests are never retracted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      if (mem_req_q && mem_gnt_i) mem_req_q <= 1'b0;
      if (mem_rvalid_i) rd_pend_q <= 1'b0;
      if (mem_req_q && mem_gnt_i && !mem_we_q) rd_pend_q <= 1'b1;
      if (!mem_req_q && pend_q) begin
        mem_req_q  <= 1'b1;
        mem_we_q   <= pend_we_q;
        mem_addr_q <= pend_addr_q;
        if (pend_we_q) mem_wdata_q <= pend_wdata_q;
        pend_q <= 1'b0;
      end
      if (new_req_c) begin
        if (mem_req_q || pend_q) begin
          pend_q       <= 1'b1;
          pend_we_q    <= new_we_c;
          pend_addr_q  <= new_addr_c;
          pend_wdata_q <= shift_nxt_c;
        end else begin
          mem_req_q  <= 1'b1;
          mem_we_q   <= new_we_c;
          mem_addr_q <= new_addr_c;
          if (new_we_c) mem_wdata_q <= shift_nxt_c;
        end
      end
    end
  end

  assign spi_sdo     = sdo_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cmd_err_o   = cmd_err_q;
  assign rd_late_o   = rd_late_q;

endmodule
